// File: rtl/lcd_cap_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_cap_pkg
// Summary  : Shared capture-FSM encoding and default widths for lcd_capture.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_cap_pkg;

    localparam int c_DATA_W_DEFAULT = 16;
    localparam int c_CNT_W_DEFAULT  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_timing_meas.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_meas
// Summary  : Measures line/frame timing from sync edges and tracks lock.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_timing_meas
    import lcd_cap_pkg::*;
#(
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hs_fall,
    input  logic             vs_fall,
    input  logic             en_lvl,
    input  logic             en_rise,
    output logic [CNT_W-1:0] meas_htotal,
    output logic [CNT_W-1:0] meas_hdisp,
    output logic [CNT_W-1:0] meas_vtotal,
    output logic [CNT_W-1:0] meas_vdisp,
    output logic             locked,
    output logic             timing_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic [CNT_W-1:0]   r_hcnt;
    logic [CNT_W-1:0]   r_ecnt;
    logic [CNT_W-1:0]   r_vcnt;
    logic [CNT_W-1:0]   r_lcnt;
    logic [4*CNT_W-1:0] r_prev;
    logic [4*CNT_W-1:0] w_cur;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_ONE;
    endfunction

    // Line figures reflect the last complete line; frame figures are taken now
    assign w_cur = {meas_htotal, meas_hdisp, r_vcnt, r_lcnt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt      <= '0;
            r_ecnt      <= '0;
            r_vcnt      <= '0;
            r_lcnt      <= '0;
            r_prev      <= '0;
            meas_htotal <= '0;
            meas_hdisp  <= '0;
            meas_vtotal <= '0;
            meas_vdisp  <= '0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            r_hcnt     <= hs_fall ? c_ONE : sat_inc(r_hcnt);
            if (en_rise) begin
                r_ecnt <= c_ONE;
            end else if (en_lvl) begin
                r_ecnt <= sat_inc(r_ecnt);
            end
            if (hs_fall) begin
                meas_htotal <= r_hcnt;
                meas_hdisp  <= r_ecnt;
            end
            if (vs_fall) begin
                meas_vtotal <= r_vcnt;
                meas_vdisp  <= r_lcnt;
                r_vcnt      <= hs_fall ? c_ONE : '0;
                r_lcnt      <= en_rise ? c_ONE : '0;
                r_prev      <= w_cur;
                if (w_cur == r_prev) begin
                    locked <= 1'b1;
                end else if (locked) begin
                    locked     <= 1'b0;
                    timing_err <= 1'b1;
                end
            end else begin
                if (hs_fall) begin
                    r_vcnt <= sat_inc(r_vcnt);
                end
                if (en_rise) begin
                    r_lcnt <= sat_inc(r_lcnt);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : lcd_capture
// Summary  : RGB LCD input capture with frame FSM and pixel coordinates.
// Options  : LCD_CAPTURE_MEASURE_EN adds timing measurement and lock check.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_capture
    import lcd_cap_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int CNT_W  = c_CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lcd_hs,
    input  logic              lcd_vs,
    input  logic              lcd_en,
    input  logic [DATA_W-1:0] lcd_rgb,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [CNT_W-1:0]  pix_xpos,
    output logic [CNT_W-1:0]  pix_ypos,
    output logic              frame_start,
    output logic              frame_done,
    output logic [CNT_W-1:0]  meas_htotal,
    output logic [CNT_W-1:0]  meas_hdisp,
    output logic [CNT_W-1:0]  meas_vtotal,
    output logic [CNT_W-1:0]  meas_vdisp,
    output logic              locked,
    output logic              timing_err
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    cap_state_t        r_state;
    cap_state_t        w_state_nxt;
    logic              r_hs1, r_hs2, r_vs1, r_vs2, r_en1, r_en2;
    logic [DATA_W-1:0] r_rgb1;
    logic [CNT_W-1:0]  r_x_cnt;
    logic [CNT_W-1:0]  r_y_cnt;
    logic              r_got_pix;
    logic              w_frame_start, w_frame_end, w_capture;
    logic              w_hs_fall, w_vs_fall, w_vs_rise, w_en_rise, w_en_fall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_CNT_MAX) ? v : v + c_ONE;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs1  <= 1'b1;
            r_hs2  <= 1'b1;
            r_vs1  <= 1'b1;
            r_vs2  <= 1'b1;
            r_en1  <= 1'b0;
            r_en2  <= 1'b0;
            r_rgb1 <= '0;
        end else begin
            r_hs1  <= lcd_hs;
            r_hs2  <= r_hs1;
            r_vs1  <= lcd_vs;
            r_vs2  <= r_vs1;
            r_en1  <= lcd_en;
            r_en2  <= r_en1;
            r_rgb1 <= lcd_rgb;
        end
    end

    assign w_hs_fall = r_hs2 & ~r_hs1;
    assign w_vs_fall = r_vs2 & ~r_vs1;
    assign w_vs_rise = ~r_vs2 & r_vs1;
    assign w_en_rise = r_en1 & ~r_en2;
    assign w_en_fall = ~r_en1 & r_en2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        case (r_state)
            ST_IDLE: if (w_vs_fall) w_state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (w_vs_rise) begin
                    w_state_nxt   = ST_RUN;
                    w_frame_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_vs_fall) begin
                    w_state_nxt = ST_SYNC;
                    w_frame_end = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A pixel coinciding with the vs falling edge belongs to no frame
    assign w_capture = (r_state == ST_RUN) && r_en1 && !w_vs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_xpos    <= '0;
            pix_ypos    <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_got_pix   <= 1'b0;
        end else begin
            pix_valid   <= w_capture;
            frame_start <= w_frame_start;
            frame_done  <= w_frame_end & r_got_pix;
            if (w_capture) begin
                pix_data <= r_rgb1;
                pix_xpos <= w_en_rise ? '0 : r_x_cnt;
                pix_ypos <= r_y_cnt;
            end
            if (w_en_rise) begin
                r_x_cnt <= w_capture ? c_ONE : '0;
            end else if (w_capture) begin
                r_x_cnt <= sat_inc(r_x_cnt);
            end
            if (w_frame_start) begin
                r_y_cnt <= '0;
            end else if ((r_state == ST_RUN) && w_en_fall) begin
                r_y_cnt <= sat_inc(r_y_cnt);
            end
            if (w_frame_start) begin
                r_got_pix <= 1'b0;
            end else if (w_capture) begin
                r_got_pix <= 1'b1;
            end
        end
    end

`ifdef LCD_CAPTURE_MEASURE_EN
    lcd_timing_meas #(
        .CNT_W (CNT_W)
    ) u_meas (
        .clk         (clk),
        .rst_n       (rst_n),
        .hs_fall     (w_hs_fall),
        .vs_fall     (w_vs_fall),
        .en_lvl      (r_en1),
        .en_rise     (w_en_rise),
        .meas_htotal (meas_htotal),
        .meas_hdisp  (meas_hdisp),
        .meas_vtotal (meas_vtotal),
        .meas_vdisp  (meas_vdisp),
        .locked      (locked),
        .timing_err  (timing_err)
    );
`else
    logic r_locked;
    logic w_unused_hs;

    // hs only feeds the measurement block
    assign w_unused_hs = w_hs_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else if (w_frame_start) begin
            r_locked <= 1'b1;
        end
    end

    assign locked      = r_locked;
    assign timing_err  = 1'b0;
    assign meas_htotal = '0;
    assign meas_hdisp  = '0;
    assign meas_vtotal = '0;
    assign meas_vdisp  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_capture
// Summary  : Scoreboard bench for lcd_capture (LCD_CAPTURE_MEASURE_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_capture;

    localparam int DATA_W  = 16;
    localparam int CNT_W   = 11;
    localparam int H_START = 4;
    localparam int V_START = 3;
    localparam int X_MAX   = 2047;

`ifdef LCD_CAPTURE_MEASURE_EN
    localparam bit c_MEAS = 1'b1;
`else
    localparam bit c_MEAS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lcd_hs, lcd_vs, lcd_en;
    logic [DATA_W-1:0] lcd_rgb;
    logic              pix_valid;
    logic [DATA_W-1:0] pix_data;
    logic [CNT_W-1:0]  pix_xpos, pix_ypos;
    logic              frame_start, frame_done;
    logic [CNT_W-1:0]  meas_htotal, meas_hdisp, meas_vtotal, meas_vdisp;
    logic              locked, timing_err;

    lcd_capture #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_hs      (lcd_hs),
        .lcd_vs      (lcd_vs),
        .lcd_en      (lcd_en),
        .lcd_rgb     (lcd_rgb),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .pix_xpos    (pix_xpos),
        .pix_ypos    (pix_ypos),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .meas_htotal (meas_htotal),
        .meas_hdisp  (meas_hdisp),
        .meas_vtotal (meas_vtotal),
        .meas_vdisp  (meas_vdisp),
        .locked      (locked),
        .timing_err  (timing_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        logic [15:0] data;
        int          x;
        int          y;
    } exp_t;

    exp_t        q[$];
    exp_t        m_e;
    int          cyc   = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_fs  = 0;
    int          n_fd  = 0;
    int          n_te  = 0;
    int          max_x = 0;
    logic [15:0] ramp  = 16'h1000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per presented pixel
    always @(negedge clk) begin
        if (frame_start) n_fs++;
        if (frame_done)  n_fd++;
        if (timing_err)  n_te++;
        if (pix_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%h at cycle %0d, expected no pixel",
                         pix_xpos, pix_ypos, pix_data, cyc);
            end else begin
                m_e = q.pop_front();
                if (int'(pix_xpos) > max_x) max_x = int'(pix_xpos);
                if (m_e.stamp != cyc || m_e.data !== pix_data ||
                    m_e.x != int'(pix_xpos) || m_e.y != int'(pix_ypos)) begin
                    n_err++;
                    $display("FAIL pixel: got cyc=%0d data=%h x=%0d y=%0d, expected cyc=%0d data=%h x=%0d y=%0d",
                             cyc, pix_data, pix_xpos, pix_ypos, m_e.stamp, m_e.data, m_e.x, m_e.y);
                end
            end
        end
    end

    function automatic logic [127:0] all_outs();
        return {pix_valid, pix_data, pix_xpos, pix_ypos, frame_start, frame_done,
                meas_htotal, meas_hdisp, meas_vtotal, meas_vdisp, locked, timing_err};
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic en,
                         input bit exp_pix, input int x, input int y);
        exp_t e;
        @(negedge clk);
        lcd_hs  = hs;
        lcd_vs  = vs;
        lcd_en  = en;
        lcd_rgb = ramp;
        if (exp_pix) begin
            e.stamp = cyc + 2;
            e.data  = ramp;
            e.x     = (x > X_MAX) ? X_MAX : x;
            e.y     = y;
            q.push_back(e);
        end
        ramp = ramp + 16'd7;
    endtask

    // Frame: vs low for lines 0-1, hs low for cols 0-1, active window from (H_START, V_START)
    task automatic send_frame(input int htot, input int hdisp, input int vtot, input int vdisp,
                              input bit exp_pix, input bit glitch, input bit sync_en,
                              input int rst_line);
        bit cap, act_line, in_win, en;
        cap = exp_pix;
        for (int ln = 0; ln < vtot; ln++) begin
            if (ln == rst_line) begin
                check("pre_reset_xpos", pix_xpos, hdisp - 1);
                check("pre_reset_ypos", pix_ypos, ln - V_START - 1);
                check("pre_reset_locked", locked, c_MEAS ? 0 : 1);
                check("pre_reset_terr_count", n_te, c_MEAS ? 1 : 0);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check("mid_reset_outputs", all_outs(), 0);
                check("mid_reset_queue_empty", q.size(), 0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                cap = 1'b0;
            end
            for (int col = 0; col < htot; col++) begin
                act_line = (ln >= V_START) && (ln < V_START + vdisp);
                in_win   = (col >= H_START) && (col < H_START + hdisp);
                en       = (act_line && in_win) || (glitch && ln == 0 && col == 0) ||
                           (sync_en && ln == 1 && in_win);
                drive(col >= 2, ln >= 2, en, cap && act_line && in_win,
                      col - H_START, ln - V_START);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        lcd_hs  = 1'b1;
        lcd_vs  = 1'b1;
        lcd_en  = 1'b0;
        lcd_rgb = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;

        // en activity before any vs edge must be ignored
        for (int ln = 0; ln < 3; ln++)
            for (int col = 0; col < 40; col++)
                drive(col >= 2, 1'b1, (col >= 4) && (col < 14), 1'b0, 0, 0);
        check("idle_frame_start_count", n_fs, 0);
        check("idle_locked", locked, 0);

        send_frame(40, 16, 12, 6, 1'b1, 1'b0, 1'b0, -1);               // A
        check("a_frame_start_count", n_fs, 1);
        check("a_locked", locked, c_MEAS ? 0 : 1);

        send_frame(40, 16, 12, 6, 1'b1, 1'b0, 1'b0, -1);               // B
        check("b_frame_start_count", n_fs, 2);
        check("b_frame_done_count", n_fd, 1);
        check("b_meas_htotal", meas_htotal, c_MEAS ? 40 : 0);
        check("b_meas_hdisp", meas_hdisp, c_MEAS ? 16 : 0);
        check("b_meas_vtotal", meas_vtotal, c_MEAS ? 12 : 0);
        check("b_meas_vdisp", meas_vdisp, c_MEAS ? 6 : 0);
        check("b_locked", locked, c_MEAS ? 0 : 1);

        send_frame(41, 16, 12, 6, 1'b1, 1'b1, 1'b0, -1);               // C: longer lines, en at vs fall
        check("c_frame_done_count", n_fd, 2);
        check("c_locked", locked, 1);
        check("c_terr_count", n_te, 0);

        send_frame(40, 16, 12, 6, 1'b1, 1'b0, 1'b0, 5);                // D: reset during line 5
        check("d_frame_done_count", n_fd, 3);
        check("d_locked_after_reset", locked, 0);

        send_frame(40, 16, 12, 6, 1'b1, 1'b0, 1'b1, -1);               // E: en pulses while in SYNC
        check("e_locked", locked, c_MEAS ? 0 : 1);

        send_frame(2110, 2100, 5, 1, 1'b1, 1'b0, 1'b0, -1);            // F: over-long line

        for (int col = 0; col < 10; col++)
            drive(col >= 2, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        check("final_frame_start_count", n_fs, 6);
        check("final_frame_done_count", n_fd, 5);
        check("final_max_xpos", max_x, X_MAX);
        check("final_queue_empty", q.size(), 0);
        check("final_terr_count", n_te, c_MEAS ? 1 : 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_capture.md
LCD_CAPTURE -- requirements
Module: lcd_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 16, pixel data width.
REQ-002 SHALL have parameter CNT_W, default 11, width of all coordinate and measurement counters.
REQ-003 SHALL have port clk  input  1  pixel clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port lcd_hs  input  1  horizontal sync, active-low.
REQ-006 SHALL have port lcd_vs  input  1  vertical sync, active-low.
REQ-007 SHALL have port lcd_en  input  1  display enable, active-high.
REQ-008 SHALL have port lcd_rgb  input  DATA_W  pixel data, valid when lcd_en=1.
REQ-009 SHALL have port pix_valid  output  1  captured pixel strobe.
REQ-010 SHALL have port pix_data  output  DATA_W  captured pixel.
REQ-011 SHALL have ports pix_xpos and pix_ypos  output  CNT_W each  pixel coordinates, 0-based.
REQ-012 SHALL have ports frame_start and frame_done  output  1 each  single-cycle pulses.
REQ-013 SHALL have ports meas_htotal, meas_hdisp, meas_vtotal, meas_vdisp  output  CNT_W each  measured timing.
REQ-014 SHALL have ports locked and timing_err  output  1 each  lock status and mismatch pulse.

Function
REQ-015 SHALL register lcd_hs/vs/en/rgb in one input stage and derive edges from stage-1 against stage-2 values.
REQ-016 SHALL assert pix_valid exactly 2 clk after each input cycle with lcd_en=1, carrying that cycle's lcd_rgb, and only in state RUN.
REQ-017 SHALL use FSM states IDLE, SYNC and RUN: IDLE->SYNC on vs falling edge; SYNC->RUN on vs rising edge; RUN->SYNC on vs falling edge.
REQ-018 SHALL pulse frame_start on SYNC->RUN, and pulse frame_done on RUN->SYNC only if at least one pixel was captured in that frame.
REQ-019 SHALL reset x to 0 on each en rising edge and increment it per valid pixel; y SHALL be 0 for the first en line after frame_start and increment on each en falling edge.
REQ-020 SHALL saturate x and y at 2^CNT_W-1, with no wrap.
REQ-021 SHALL ignore en pulses in IDLE/SYNC, producing no pix_valid.
REQ-022 SHALL handle an en rising edge in the same cycle as a vs falling edge by ending the frame; that pixel is dropped.

Reset
REQ-023 SHALL, while rst_n=0, set FSM=IDLE, all outputs to 0, all counters and input stages to 0 (hs/vs stages to 1).
REQ-024 SHALL, on reset mid-frame, discard the partial frame and require a fresh vs falling edge before capture.

Configuration
REQ-025 SHALL, with macro LCD_CAPTURE_MEASURE_EN defined: set meas_htotal = clocks between consecutive hs falling edges, meas_hdisp = en length of last line, meas_vtotal = hs falling edges between vs falling edges, meas_vdisp = en lines per frame, all updated at vs falling edge (htotal/hdisp at hs falling edge).
REQ-026 SHALL, with LCD_CAPTURE_MEASURE_EN defined, set locked after two consecutive frames with identical four measurements; a differing frame while locked SHALL pulse timing_err one cycle and clear locked.
REQ-027 SHALL, without LCD_CAPTURE_MEASURE_EN, tie the meas_* outputs and timing_err to 0, and set locked=1 from the first frame_start until reset.

Structure
REQ-028 SHALL place the FSM state encoding and the CNT_W/DATA_W defaults in shared package lcd_cap_pkg.
REQ-029 SHALL implement measurement in sub-module lcd_timing_meas, instantiated only under LCD_CAPTURE_MEASURE_EN.

Verification
REQ-030 SHALL cover: 480x272 timing (H_TOTAL 525, V_TOTAL 286) -> 130560 pix_valid per frame, last pixel x=479 y=271, one frame_done.
REQ-031 SHALL cover: data ramp on lcd_rgb -> pix_data equals input delayed exactly 2 clk.
REQ-032 SHALL cover: en active before first vs -> zero pix_valid until the first frame_start.
REQ-033 SHALL cover (MEASURE_EN): two identical frames -> locked=1, meas_htotal=525, meas_vdisp=272; third frame with H_TOTAL 526 -> timing_err pulse, locked=0.
REQ-034 SHALL cover: rst_n low during line 100 -> outputs 0 immediately; after release no pixels until the next vs falling-then-rising sequence.
REQ-035 SHALL cover: an en line of 2100 clocks -> pix_xpos saturates at 2047.
